// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the cache-to-memory arbiter:
//               bus widths, dcache request type, FSM state enum, requester id
//               enum and a power-of-two helper used for parameter checks.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int MEM_ADDR_BUS         = 12;
    localparam int MEM_DATA_BUS         = 128;
    localparam int MEM_TRANSFERS_PER_CL = 4;

    typedef enum logic [0:0] {
        DMEM_READ  = 1'b0,
        DMEM_WRITE = 1'b1
    } dmem_rtype_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_arb_state_t;

    typedef enum logic [0:0] {
        ARB_IC = 1'b0,
        ARB_DC = 1'b1
    } mem_arb_id_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational tie-break between the icache and dcache
//               requesters. On a tie the requester that was NOT granted last
//               (i_ptr) wins.
// Ports       : i_ic_req  - icache request valid
//               i_dc_req  - dcache request valid
//               i_ptr     - id of the requester granted last
//               o_grant   - one-hot grant, bit0 = ic, bit1 = dc
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic        i_ic_req,
    input  logic        i_dc_req,
    input  mem_arb_id_t i_ptr,
    output logic [1:0]  o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_ic_req && i_dc_req) begin
            o_grant = (i_ptr == ARB_IC) ? 2'b10 : 2'b01;
        end else if (i_dc_req) begin
            o_grant = 2'b10;
        end else if (i_ic_req) begin
            o_grant = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates icache line reads and dcache line reads/writes onto
//               a single beat-oriented memory port. A granted line transfer
//               issues BEATS consecutive beat requests; read beats are routed
//               back to the granted requester with zero latency, and a
//               one-cycle ready pulse acknowledges the completed line.
// Config      : MEM_ARB_RR_EN - when defined, ties are broken round-robin
//               (pointer updated in DONE); otherwise dc has fixed priority.
// Ports       : clk, rst_n              - clock, async active-low reset
//               ic_req_* / ic_rsp_*     - icache line read request / beats
//               dc_req_* / dc_rsp_*     - dcache line request / read beats
//               dc_wdata / dc_wdata_ready - dcache write beat handshake
//               mem_req_* / mem_rsp_*   - memory beat request / read return
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW    = MEM_ADDR_BUS,
    parameter int DW    = MEM_DATA_BUS,
    parameter int BEATS = MEM_TRANSFERS_PER_CL
) (
    input  logic          clk,
    input  logic          rst_n,
    // icache
    input  logic          ic_req_valid,
    output logic          ic_req_ready,
    input  logic [AW-1:0] ic_req_addr,
    output logic          ic_rsp_valid,
    output logic [DW-1:0] ic_rsp_data,
    // dcache
    input  logic          dc_req_valid,
    output logic          dc_req_ready,
    input  logic [AW-1:0] dc_req_addr,
    input  dmem_rtype_t   dc_req_rtype,
    input  logic [DW-1:0] dc_wdata,
    output logic          dc_wdata_ready,
    output logic          dc_rsp_valid,
    output logic [DW-1:0] dc_rsp_data,
    // memory
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    output logic          mem_req_we,
    output logic [DW-1:0] mem_req_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data
);

    localparam int            c_lb    = $clog2(BEATS);
    localparam int            c_cw    = c_lb + 1;
    localparam logic [c_cw-1:0] c_beats = c_cw'(BEATS);
    localparam logic [c_cw-1:0] c_last  = c_cw'(BEATS - 1);
    localparam logic [c_cw-1:0] c_one   = c_cw'(1);

    generate
        if (!is_pow2(BEATS) || (BEATS < 2)) begin : g_beats_check
            $error("mem_arbiter: BEATS must be a power of two and at least 2");
        end
    endgenerate

    mem_arb_state_t        r_state;
    mem_arb_state_t        w_state_nxt;
    mem_arb_id_t           r_grant;
    logic                  r_we;
    logic [AW-c_lb-1:0]    r_base_hi;
    logic [c_cw-1:0]       r_issue_cnt;
    logic [c_cw-1:0]       r_rsp_cnt;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_rsp;
    logic                  w_done;
    logic [1:0]            w_pick;
    mem_arb_id_t           w_gnt_id;
    mem_arb_id_t           w_ptr;

    // Line-offset bits of the request addresses are replaced by the beat
    // counter, so they are intentionally not consumed.
    logic [2*c_lb-1:0]     w_unused_lsb;
    assign w_unused_lsb = {ic_req_addr[c_lb-1:0], dc_req_addr[c_lb-1:0]};

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
    mem_arb_id_t r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ARB_IC;
        end else if (r_state == DONE) begin
            r_ptr <= r_grant;
        end
    end

    assign w_ptr = r_ptr;
`else
    // Pinning "last granted" to ic makes every tie resolve to dc.
    assign w_ptr = ARB_IC;
`endif

    mem_arb_pick u_pick (
        .i_ic_req (ic_req_valid),
        .i_dc_req (dc_req_valid),
        .i_ptr    (w_ptr),
        .o_grant  (w_pick)
    );

    assign w_gnt_id = (w_pick == 2'b10) ? ARB_DC : ARB_IC;
    assign w_start  = (r_state == IDLE) && (ic_req_valid || dc_req_valid);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        mem_req_valid  = 1'b0;
        mem_req_addr   = '0;
        mem_req_we     = 1'b0;
        mem_req_wdata  = '0;
        dc_wdata_ready = 1'b0;
        ic_rsp_valid   = 1'b0;
        ic_rsp_data    = '0;
        dc_rsp_valid   = 1'b0;
        dc_rsp_data    = '0;
        ic_req_ready   = 1'b0;
        dc_req_ready   = 1'b0;
        w_accept       = 1'b0;
        w_rsp          = 1'b0;
        w_done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = BUSY;
                end
            end

            BUSY: begin
                if (r_issue_cnt < c_beats) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {r_base_hi, r_issue_cnt[c_lb-1:0]};
                    mem_req_we    = r_we;
                    if (r_we) begin
                        mem_req_wdata = dc_wdata;
                    end
                    w_accept = mem_req_ready;
                end
                dc_wdata_ready = w_accept && r_we;

                // Responses are only meaningful for a read still expecting beats.
                if (!r_we && mem_rsp_valid && (r_rsp_cnt < c_beats)) begin
                    w_rsp = 1'b1;
                    if (r_grant == ARB_DC) begin
                        dc_rsp_valid = 1'b1;
                        dc_rsp_data  = mem_rsp_data;
                    end else begin
                        ic_rsp_valid = 1'b1;
                        ic_rsp_data  = mem_rsp_data;
                    end
                end

                w_done = r_we ? (w_accept && (r_issue_cnt == c_last))
                              : (w_rsp && (r_rsp_cnt == c_last));
                if (w_done) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                ic_req_ready = (r_grant == ARB_IC);
                dc_req_ready = (r_grant == ARB_DC);
                w_state_nxt  = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction context and beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= ARB_IC;
            r_we        <= 1'b0;
            r_base_hi   <= '0;
            r_issue_cnt <= '0;
            r_rsp_cnt   <= '0;
        end else if (w_start) begin
            r_grant     <= w_gnt_id;
            r_we        <= (w_gnt_id == ARB_DC) && (dc_req_rtype == DMEM_WRITE);
            r_base_hi   <= (w_gnt_id == ARB_DC) ? dc_req_addr[AW-1:c_lb]
                                                : ic_req_addr[AW-1:c_lb];
            r_issue_cnt <= '0;
            r_rsp_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_issue_cnt <= r_issue_cnt + c_one;
            end
            if (w_rsp) begin
                r_rsp_cnt <= r_rsp_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A line-level reference
//               model predicts every output each cycle; directed scenarios
//               add hand-computed expectations (addresses, pulse counts,
//               ack timing, grant order, reset behaviour).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 12;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req_valid = 1'b0;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_addr = '0;
    logic          ic_rsp_valid;
    logic [DW-1:0] ic_rsp_data;
    logic          dc_req_valid = 1'b0;
    logic          dc_req_ready;
    logic [AW-1:0] dc_req_addr = '0;
    dmem_rtype_t   dc_req_rtype = DMEM_READ;
    logic [DW-1:0] dc_wdata = '0;
    logic          dc_wdata_ready;
    logic          dc_rsp_valid;
    logic [DW-1:0] dc_rsp_data;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_we;
    logic [DW-1:0] mem_req_wdata;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_data = '0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_rtype(dc_req_rtype), .dc_wdata(dc_wdata), .dc_wdata_ready(dc_wdata_ready),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- cycle counter, memory responder, input driver -------
    typedef struct { int due; logic [DW-1:0] data; } rsp_t;
    typedef struct { logic we; logic [AW-1:0] addr; } acc_t;
    rsp_t q_rsp[$];
    acc_t q_acc[$];
    int   q_ack[$];
    int   cyc = 0;
    bit   rmode = 1'b0;   // 0: ready always 1, 1: ready toggles
    bit   inj_rsp = 1'b0; // force one stray response

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        dc_wdata = {$urandom, $urandom, $urandom, $urandom};
        if (rmode) mem_req_ready = ~mem_req_ready;
        else       mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        while (q_rsp.size() > 0 && q_rsp[0].due < cyc) void'(q_rsp.pop_front());
        if (q_rsp.size() > 0 && q_rsp[0].due == cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = q_rsp[0].data;
            void'(q_rsp.pop_front());
        end
        if (inj_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        end
    end

    // ---------------- line-level reference model + monitor ----------------
    bit m_act = 0, m_done = 0, m_wr = 0;
    int m_gnt = 0, m_last = 0, m_line = 0, m_iss = 0, m_got = 0;
    int n_ic_rsp = 0, n_dc_rsp = 0, n_ic_ack = 0, n_dc_ack = 0;
    int n_wrdy = 0, n_misalign = 0;
    int last_ic_rsp_cyc = 0, last_acc_cyc = 0, last_ack_cyc = 0;

    always @(negedge clk) begin
        logic          e_icrdy, e_icv, e_dcrdy, e_dcv, e_wrdy, e_mv, e_we, hit;
        logic [DW-1:0] e_icd, e_dcd, e_wd;
        logic [AW-1:0] e_addr;
        e_icrdy = 0; e_icv = 0; e_dcrdy = 0; e_dcv = 0; e_wrdy = 0; e_mv = 0; e_we = 0;
        e_icd = '0; e_dcd = '0; e_wd = '0; e_addr = '0; hit = 0;

        if (!rst_n) begin
            m_act = 0; m_done = 0; m_last = 0;
        end else if (m_done) begin
            e_icrdy = (m_gnt == 0);
            e_dcrdy = (m_gnt == 1);
            m_last  = m_gnt;
            m_done  = 0;
        end else if (m_act) begin
            if (m_iss < 4) begin
                e_mv   = 1;
                e_addr = AW'(m_line * 4 + m_iss);
                e_we   = m_wr;
                if (m_wr) begin
                    e_wd   = dc_wdata;
                    e_wrdy = mem_req_ready;
                end
            end
            if (!m_wr && mem_rsp_valid && m_got < 4) begin
                hit = 1;
                if (m_gnt == 1) begin e_dcv = 1; e_dcd = mem_rsp_data; end
                else            begin e_icv = 1; e_icd = mem_rsp_data; end
            end
            if (e_mv && mem_req_ready) m_iss++;
            if (hit) m_got++;
            if ((m_wr && m_iss == 4) || (!m_wr && m_got == 4)) begin
                m_act = 0; m_done = 1;
            end
        end else if (ic_req_valid || dc_req_valid) begin
            if (ic_req_valid && dc_req_valid) begin
`ifdef MEM_ARB_RR_EN
                m_gnt = (m_last == 0) ? 1 : 0;
`else
                m_gnt = 1;
`endif
            end else begin
                m_gnt = dc_req_valid ? 1 : 0;
            end
            m_line = (m_gnt == 1) ? int'(dc_req_addr) / 4 : int'(ic_req_addr) / 4;
            m_wr   = (m_gnt == 1) && (dc_req_rtype == DMEM_WRITE);
            m_iss  = 0; m_got = 0; m_act = 1;
        end

        chk("ic_req_ready",   ic_req_ready,   e_icrdy);
        chk("ic_rsp_valid",   ic_rsp_valid,   e_icv);
        chk("ic_rsp_data",    ic_rsp_data,    e_icd);
        chk("dc_req_ready",   dc_req_ready,   e_dcrdy);
        chk("dc_rsp_valid",   dc_rsp_valid,   e_dcv);
        chk("dc_rsp_data",    dc_rsp_data,    e_dcd);
        chk("dc_wdata_ready", dc_wdata_ready, e_wrdy);
        chk("mem_req_valid",  mem_req_valid,  e_mv);
        chk("mem_req_addr",   mem_req_addr,   e_addr);
        chk("mem_req_we",     mem_req_we,     e_we);
        chk("mem_req_wdata",  mem_req_wdata,  e_wd);

        if (mem_req_valid && mem_req_ready) begin
            q_acc.push_back('{we: mem_req_we, addr: mem_req_addr});
            last_acc_cyc = cyc;
            if (!mem_req_we)
                q_rsp.push_back('{due: cyc + 2, data: {4{8'h5A, 12'(cyc), mem_req_addr}}});
        end
        if (dc_wdata_ready) begin
            n_wrdy++;
            if (!(mem_req_valid && mem_req_ready)) n_misalign++;
        end
        if (ic_rsp_valid) begin n_ic_rsp++; last_ic_rsp_cyc = cyc; end
        if (dc_rsp_valid) n_dc_rsp++;
        if (ic_req_ready) begin n_ic_ack++; q_ack.push_back(0); last_ack_cyc = cyc; end
        if (dc_req_ready) begin n_dc_ack++; q_ack.push_back(1); last_ack_cyc = cyc; end
    end

    // ---------------- directed scenarios ----------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (q_ack.size() >= target) begin ok = 1; break; end
        end
    endtask

    initial begin
        int  c0, s_acc, s_icr, s_ica, s_dca, s_dcr, s_wr, s_mis, s_ack, s_icr2;
        bit  ok;
        int  exp_order[4];

        #1;
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_ic_req_ready",  ic_req_ready,  0);
        chk("reset_mem_req_addr",  mem_req_addr,  0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // ---- ic line read at 0x0A5, ready=1, response latency 2
        s_acc = q_acc.size(); s_icr = n_ic_rsp; s_ica = n_ic_ack; s_ack = q_ack.size();
        c0 = cyc;
        ic_req_valid = 1'b1; ic_req_addr = 12'h0A5;
        tick(1);
        ic_req_valid = 1'b0; ic_req_addr = 12'hFFF;   // must be ignored after grant
        wait_acks(s_ack + 1, 40, ok);
        chk("t1_ack_seen", ok, 1);
        tick(2);
        chk("t1_beats", q_acc.size() - s_acc, 4);
        for (int i = 0; i < 4 && s_acc + i < q_acc.size(); i++) begin
            chk("t1_addr", q_acc[s_acc + i].addr, 12'h0A4 + 12'(i));
            chk("t1_we",   q_acc[s_acc + i].we,   0);
        end
        chk("t1_rsp_beats", n_ic_rsp - s_icr, 4);
        chk("t1_ack_count", n_ic_ack - s_ica, 1);
        chk("t1_ack_cycle", last_ack_cyc - c0, 7);
        chk("t1_ack_after_last_rsp", last_ack_cyc, last_ic_rsp_cyc + 1);

        // ---- dc line write at 0x100, ready toggling
        @(negedge clk); #1;
        rmode = 1'b1;
        @(posedge clk); #1;
        s_acc = q_acc.size(); s_wr = n_wrdy; s_mis = n_misalign; s_dca = n_dc_ack; s_ack = q_ack.size();
        c0 = cyc;
        dc_req_valid = 1'b1; dc_req_addr = 12'h100; dc_req_rtype = DMEM_WRITE;
        tick(1);
        dc_req_valid = 1'b0; dc_req_addr = 12'h7FF; dc_req_rtype = DMEM_READ;
        wait_acks(s_ack + 1, 40, ok);
        chk("t2_ack_seen", ok, 1);
        rmode = 1'b0;
        tick(2);
        chk("t2_beats", q_acc.size() - s_acc, 4);
        for (int i = 0; i < 4 && s_acc + i < q_acc.size(); i++) begin
            chk("t2_addr", q_acc[s_acc + i].addr, 12'h100 + 12'(i));
            chk("t2_we",   q_acc[s_acc + i].we,   1);
        end
        chk("t2_wdata_ready_pulses", n_wrdy - s_wr, 4);
        chk("t2_wdata_ready_aligned", n_misalign - s_mis, 0);
        chk("t2_ack_count", n_dc_ack - s_dca, 1);
        chk("t2_ack_cycle", last_ack_cyc - c0, 8);
        chk("t2_ack_after_last_accept", last_ack_cyc, last_acc_cyc + 1);

        // ---- reset after 2 beats of a dc read
        s_dcr = n_dc_rsp; s_dca = n_dc_ack; s_icr = n_ic_rsp;
        dc_req_valid = 1'b1; dc_req_addr = 12'h200; dc_req_rtype = DMEM_READ;
        tick(1);
        dc_req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (n_dc_rsp - s_dcr >= 2) begin ok = 1; break; end
        end
        chk("t4_two_beats_seen", ok, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_mem_req_valid", mem_req_valid, 0);
        chk("t4_rst_mem_req_addr",  mem_req_addr,  0);
        chk("t4_rst_dc_rsp_valid",  dc_rsp_valid,  0);
        chk("t4_rst_dc_req_ready",  dc_req_ready,  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s_dcr = n_dc_rsp; s_icr2 = n_ic_rsp;
        tick(3);
        @(negedge clk); #1;
        inj_rsp = 1'b1;           // stray response while idle
        @(negedge clk); #1;
        inj_rsp = 1'b0;
        tick(4);
        chk("t4_no_dc_ack",      n_dc_ack - s_dca, 0);
        chk("t4_no_dc_rsp_after", n_dc_rsp - s_dcr, 0);
        chk("t4_no_ic_rsp_after", n_ic_rsp - s_icr2, 0);
        chk("t4_ic_untouched",    n_ic_rsp - s_icr, 0);

        // ---- both requesting continuously, first tie after reset
        s_ack = q_ack.size();
        ic_req_valid = 1'b1; ic_req_addr = 12'h040;
        dc_req_valid = 1'b1; dc_req_addr = 12'h300; dc_req_rtype = DMEM_WRITE;
        wait_acks(s_ack + 4, 200, ok);
        chk("t3_four_acks", ok, 1);
        ic_req_valid = 1'b0; dc_req_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        for (int i = 0; i < 4 && s_ack + i < q_ack.size(); i++)
            chk("t3_grant_order", q_ack[s_ack + i], exp_order[i]);
        tick(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default MEM_ADDR_BUS (12): memory beat-address width.
REQ-002 SHALL have parameter DW, default MEM_DATA_BUS (128): memory beat-data width.
REQ-003 SHALL have parameter BEATS, default MEM_TRANSFERS_PER_CL (4): beats per cache line; elaboration error if is_pow2(BEATS) is false.
REQ-004 SHALL use a single clock and an asynchronous, active-low reset; clock and reset ports as below.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ic_req_valid / ic_req_ready / ic_req_addr  in/out/in  1/1/AW  icache line-read request; ready is a one-cycle completion ack.
REQ-008 ic_rsp_valid / ic_rsp_data  out/out  1/DW  icache read beat return.
REQ-009 dc_req_valid / dc_req_ready / dc_req_addr / dc_req_rtype  in/out/in/in  1/1/AW/dmem_rtype_t  dcache line request; ready is a one-cycle completion ack.
REQ-010 dc_wdata / dc_wdata_ready  in/out  DW/1  dcache write beat; ready pulses when the current beat is accepted by memory.
REQ-011 dc_rsp_valid / dc_rsp_data  out/out  1/DW  dcache read beat return.
REQ-012 mem_req_valid / mem_req_ready / mem_req_addr / mem_req_we / mem_req_wdata  out/in/out/out/out  1/1/AW/1/DW  memory beat request.
REQ-013 mem_rsp_valid / mem_rsp_data  in/in  1/DW  memory read-beat return, in issue order.

Function
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 IDLE: when any req_valid is high, register grant, base address with low log2(BEATS) bits forced to 0, and we (ic: read; dc: rtype==DMEM_WRITE); go to BUSY next cycle.
REQ-016 Both valid in IDLE: grant follows REQ-030/031.
REQ-017 BUSY: mem_req_valid=1 while issue_cnt<BEATS; mem_req_addr={base[AW-1:log2(BEATS)], issue_cnt}; issue_cnt increments on mem_req_valid&&mem_req_ready.
REQ-018 Write: mem_req_wdata=dc_wdata, mem_req_we=1; dc_wdata_ready=mem_req_valid&&mem_req_ready (combinational); completion when beat BEATS-1 is accepted.
REQ-019 Read: mem_req_we=0; each mem_rsp_valid increments rsp_cnt and is routed combinationally to the granted requester's rsp_valid/rsp_data (zero latency); completion on response BEATS-1.
REQ-020 A read response may arrive in the same cycle as a later beat is issued; both counters update that cycle.
REQ-021 On completion go to DONE; DONE asserts granted req_ready for exactly one cycle, then IDLE; no new grant is issued in the DONE cycle.
REQ-022 Minimum write transaction (mem_req_ready always 1): valid seen cycle 0, beats cycles 1..4, ack cycle 5.
REQ-023 Requester inputs (valid/addr/rtype) other than dc_wdata are ignored after grant; only the latched values are used.
REQ-024 mem_rsp_valid outside a BUSY read, or for the non-granted requester, is dropped; no rsp_valid asserted.
REQ-025 Counters are log2(BEATS)+1 bits wide; they never wrap within a transaction and are cleared on entry to BUSY.

Reset
REQ-026 During reset: state=IDLE, counters=0, grant=ic, rr pointer=ic.
REQ-027 All *_valid and *_ready outputs are 0 during reset; address/data outputs are 0.
REQ-028 Reset mid-transaction abandons it: no ack is issued; responses arriving after reset release are dropped per REQ-024.
REQ-029 First grant after reset with both valid goes to dc.

Configuration
REQ-030 With MEM_ARB_RR_EN defined: round-robin; on a tie the requester not granted last wins; the pointer updates at DONE.
REQ-031 Without MEM_ARB_RR_EN: fixed priority, dc always wins a tie; no pointer flop.

Structure
REQ-032 The FSM state enum (mem_arb_state_t) and the requester id enum (mem_arb_id_t: ARB_IC, ARB_DC) live in the shared types package.
REQ-033 The tie-break logic is a sub-module, mem_arb_pick: combinational, two requests plus pointer in, one-hot grant out.

Verification
REQ-034 ic read at 0x0A5, mem_req_ready=1, responses 2 cycles after issue: mem addrs 0x0A4..0x0A7 with we=0; four ic_rsp_valid beats; ic_req_ready pulses once after beat 3.
REQ-035 dc write at 0x100 with mem_req_ready toggling 1,0,1,0…: exactly 4 dc_wdata_ready pulses aligned with accepts; ack in cycle after the 4th accept.
REQ-036 ic and dc both valid continuously, RR build: grants alternate dc, ic, dc, ic; non-RR build: dc only, ic starved.
REQ-037 rst_n asserted after 2 beats of a dc read: outputs go 0 immediately; no dc_req_ready; a stray mem_rsp_valid after release produces no rsp_valid.
REQ-038 mem_rsp_valid injected in IDLE: no ic_rsp_valid or dc_rsp_valid.
